r2sdf_bf_16: RTL and testbench

Radix-2 single-path delay-feedback butterfly stage for the FFT_R2SDF pipeline, with a 16-word feedback delay.
- Drives the existing 16-deep complex delay line: enable plus 34-bit write data.
- Consumes that delay line's 34-bit tail output.
- Produces the stage's sum/difference stream for the downstream twiddle multiplier.
- Contains the stage's sample counter, phase control and output-valid logic.

---
 rtl/fft_r2sdf_pkg.sv | 9 +
 rtl/r2sdf_bf_ctrl.sv | 32 +++
 rtl/r2sdf_bf_16.sv | 68 ++++++
 tb/tb_r2sdf_bf_16.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fft_r2sdf_pkg.sv
// fft_r2sdf_pkg: shared widths and phase encoding for the R2SDF butterfly stages.
package fft_r2sdf_pkg;
  localparam int DW = 33;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(2 * DEPTH);
  localparam int BW = DW + 1;
  localparam logic PH_FILL = 1'b0;
  localparam logic PH_BF = 1'b1;
endpackage

// File: rtl/r2sdf_bf_ctrl.sv
// r2sdf_bf_ctrl: sample counter, fill/butterfly phase and primed flag for an R2SDF stage.
module r2sdf_bf_ctrl #(
  parameter int DEPTH = fft_r2sdf_pkg::DEPTH,
  parameter int CW = fft_r2sdf_pkg::CW
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iValid,
  output logic oPhase,
  output logic oPrimed
);
  import fft_r2sdf_pkg::*;
  logic [CW-1:0] cnt_q, cnt_d;
  logic primed_q, primed_d;
  logic wrap;
  always_comb begin
    wrap = iValid && (cnt_q == CW'(2 * DEPTH - 1));
    cnt_d = !iValid ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    primed_d = primed_q | wrap;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q <= '0;
      primed_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      primed_q <= primed_d;
    end
  end
  assign oPhase = cnt_q[CW-1];
  assign oPrimed = primed_q;
endmodule

// File: rtl/r2sdf_bf_16.sv
// r2sdf_bf_16: radix-2 SDF butterfly with a 16-word external feedback delay line.
module r2sdf_bf_16 #(
  parameter int DW = fft_r2sdf_pkg::DW,
  parameter int DEPTH = fft_r2sdf_pkg::DEPTH,
  parameter int CW = fft_r2sdf_pkg::CW
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iValid,
  input  logic [DW-1:0] iData_Re,
  input  logic [DW-1:0] iData_Im,
  output logic          oBuf_En,
  output logic [DW:0]   oBuf_Re,
  output logic [DW:0]   oBuf_Im,
  input  logic [DW:0]   iBuf_Re,
  input  logic [DW:0]   iBuf_Im,
  output logic          oValid,
  output logic [DW:0]   oData_Re,
  output logic [DW:0]   oData_Im,
  output logic          oDiff
);
  import fft_r2sdf_pkg::*;
  logic phase, primed, bf;
  logic [DW:0] in_re, in_im, sum_re, sum_im, dif_re, dif_im;
  logic [DW:0] data_re_q, data_re_d, data_im_q, data_im_d;
  logic valid_q, valid_d, diff_q, diff_d;
  r2sdf_bf_ctrl #(.DEPTH(DEPTH), .CW(CW)) u_ctrl (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iValid(iValid),
    .oPhase(phase),
    .oPrimed(primed)
  );
  // In the butterfly phase iBuf is a sign-extended DW-bit sample, so DW+1 bits never wrap.
  always_comb begin
    bf = (phase == PH_BF);
    in_re = {iData_Re[DW-1], iData_Re};
    in_im = {iData_Im[DW-1], iData_Im};
    sum_re = iBuf_Re + in_re;
    sum_im = iBuf_Im + in_im;
    dif_re = iBuf_Re - in_re;
    dif_im = iBuf_Im - in_im;
    oBuf_En = iValid;
    oBuf_Re = bf ? dif_re : in_re;
    oBuf_Im = bf ? dif_im : in_im;
    valid_d = iValid & (bf | primed);
    diff_d = iValid ? !bf : diff_q;
    data_re_d = !iValid ? data_re_q : bf ? sum_re : iBuf_Re;
    data_im_d = !iValid ? data_im_q : bf ? sum_im : iBuf_Im;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      valid_q <= 1'b0;
      diff_q <= 1'b0;
      data_re_q <= '0;
      data_im_q <= '0;
    end else begin
      valid_q <= valid_d;
      diff_q <= diff_d;
      data_re_q <= data_re_d;
      data_im_q <= data_im_d;
    end
  end
  assign oValid = valid_q;
  assign oDiff = diff_q;
  assign oData_Re = data_re_q;
  assign oData_Im = data_im_q;
endmodule

// File: tb/tb_r2sdf_bf_16.sv
// tb_r2sdf_bf_16: randomized bench for r2sdf_bf_16 against a frame-level reference model.
module tb_r2sdf_bf_16;
  localparam int DW = 33;
  logic iClk = 1'b0, iRst_n = 1'b0, iValid = 1'b0;
  logic [DW-1:0] iData_Re = '0, iData_Im = '0;
  logic oBuf_En, oValid, oDiff;
  logic [DW:0] oBuf_Re, oBuf_Im, iBuf_Re, iBuf_Im, oData_Re, oData_Im;
  int n_chk = 0, n_err = 0;

  r2sdf_bf_16 dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid),
    .iData_Re(iData_Re), .iData_Im(iData_Im),
    .oBuf_En(oBuf_En), .oBuf_Re(oBuf_Re), .oBuf_Im(oBuf_Im),
    .iBuf_Re(iBuf_Re), .iBuf_Im(iBuf_Im),
    .oValid(oValid), .oData_Re(oData_Re), .oData_Im(oData_Im), .oDiff(oDiff)
  );

  always #5 iClk = ~iClk;

  // external 16-deep delay line (not reset)
  logic [DW:0] dl_re [16], dl_im [16];
  initial for (int i = 0; i < 16; i++) begin dl_re[i] = '0; dl_im[i] = '0; end
  always @(posedge iClk)
    if (oBuf_En) begin
      dl_re[0] <= oBuf_Re;
      dl_im[0] <= oBuf_Im;
      for (int i = 1; i < 16; i++) begin dl_re[i] <= dl_re[i-1]; dl_im[i] <= dl_im[i-1]; end
    end
  assign iBuf_Re = dl_re[15];
  assign iBuf_Im = dl_im[15];

  function automatic logic [DW:0] sx(input logic [DW-1:0] x);
    return {x[DW-1], x};
  endfunction

  // reference: position in frame, first-half samples, last frame's differences
  int idx_m;
  logic primed_m, ev, edf;
  logic [DW:0] ed_re, ed_im;
  logic [DW:0] a_re [16], a_im [16], d_re [16], d_im [16];
  always @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      idx_m <= 0; primed_m <= 1'b0; ev <= 1'b0; edf <= 1'b0; ed_re <= '0; ed_im <= '0;
    end else if (iValid) begin
      if (idx_m < 16) begin
        a_re[idx_m] <= sx(iData_Re);
        a_im[idx_m] <= sx(iData_Im);
        ed_re <= d_re[idx_m];
        ed_im <= d_im[idx_m];
        edf <= 1'b1;
        ev <= primed_m;
      end else begin
        d_re[idx_m-16] <= a_re[idx_m-16] - sx(iData_Re);
        d_im[idx_m-16] <= a_im[idx_m-16] - sx(iData_Im);
        ed_re <= a_re[idx_m-16] + sx(iData_Re);
        ed_im <= a_im[idx_m-16] + sx(iData_Im);
        edf <= 1'b0;
        ev <= 1'b1;
      end
      idx_m <= (idx_m + 1) % 32;
      if (idx_m == 31) primed_m <= 1'b1;
    end else ev <= 1'b0;

  task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, $signed(act), $signed(exp));
    end
  endtask

  always @(negedge iClk) begin
    chk("oValid", {{DW{1'b0}}, oValid}, {{DW{1'b0}}, ev});
    if (ev) begin
      chk("oData_Re", oData_Re, ed_re);
      chk("oData_Im", oData_Im, ed_im);
      chk("oDiff", {{DW{1'b0}}, oDiff}, {{DW{1'b0}}, edf});
    end
  end

  logic [DW:0] ob_re;
  task automatic drive(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(negedge iClk);
    iValid = v; iData_Re = re; iData_Im = im;
    #1;
    chk("oBuf_En", {{DW{1'b0}}, oBuf_En}, {{DW{1'b0}}, v});
    if (v) begin
      chk("oBuf_Re", oBuf_Re, idx_m < 16 ? sx(re) : a_re[idx_m-16] - sx(re));
      chk("oBuf_Im", oBuf_Im, idx_m < 16 ? sx(im) : a_im[idx_m-16] - sx(im));
    end
    ob_re = oBuf_Re;
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {1'($urandom_range(0, 1)), 32'($urandom)};
  endfunction

  task automatic pulse_reset();
    #1 iRst_n = 1'b0;
    #1;
    chk("rst_oValid", {{DW{1'b0}}, oValid}, '0);
    chk("rst_oData_Re", oData_Re, '0);
    chk("rst_oData_Im", oData_Im, '0);
    #1 iRst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge iClk);
    #1;
    chk("reset_oValid", {{DW{1'b0}}, oValid}, '0);
    chk("reset_oData_Re", oData_Re, '0);
    chk("reset_oDiff", {{DW{1'b0}}, oDiff}, '0);
    #2 iRst_n = 1'b1;
    // frame 1: ramp on Re
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, DW'(n), '0);
      if (n == 0) chk("ramp_no_valid", {{DW{1'b0}}, oValid}, '0);
      if (n == 16) begin
        chk("ramp_first_valid", {{DW{1'b0}}, oValid}, 34'd1);
        chk("ramp_first_sum", oData_Re, 34'd16);
        chk("ramp_first_diffflag", {{DW{1'b0}}, oDiff}, '0);
      end
      if (n == 31) chk("ramp_last_sum", oData_Re, 34'd46);
    end
    // frame 2: zeros, phase-0 outputs carry the -16 differences
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, '0, '0);
      if (n == 0) begin
        chk("f2_diff_re", oData_Re, 34'h3_FFFF_FFF0);
        chk("f2_diff_flag", {{DW{1'b0}}, oDiff}, 34'd1);
        chk("f2_diff_im", oData_Im, '0);
      end
      if (n == 20) chk("f2_sum_zero", oData_Re, '0);
    end
    // extremes
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, n < 16 ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF, rnd());
      if (n == 16) begin
        chk("ext_sum", oData_Re, 34'h3_FFFF_FFFF);
        chk("ext_buf_diff", ob_re, 34'h2_0000_0001);
      end
    end
    // toggling iValid
    for (int n = 0; n < 64; n++) drive(n % 2 == 0, rnd(), rnd());
    // reset mid-frame at sample 20 of the second frame
    for (int n = 0; n < 52; n++) drive(1'b1, rnd(), rnd());
    pulse_reset();
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, rnd(), rnd());
      chk("post_rst_suppress", {{DW{1'b0}}, oValid}, '0);
    end
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, rnd(), rnd());
      chk("post_rst_sum_valid", {{DW{1'b0}}, oValid}, 34'd1);
    end
    for (int n = 0; n < 32; n++) drive(1'b1, rnd(), rnd());
    // Im-only ramp
    pulse_reset();
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, '0, DW'(n));
      if (n == 16) begin
        chk("im_first_sum", oData_Im, 34'd16);
        chk("im_re_zero", oData_Re, '0);
      end
      if (n == 31) chk("im_last_sum", oData_Im, 34'd46);
    end
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, '0, '0);
      if (n == 0) chk("im_diff", oData_Im, 34'h3_FFFF_FFF0);
    end
    // random stress with gaps
    for (int n = 0; n < 600; n++) drive($urandom_range(0, 3) != 0, rnd(), rnd());
    repeat (2) drive(1'b0, '0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
